// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths, iteration count, FSM states and opcode/register constants for multdiv_iter_unit
package multdiv_pkg;
   localparam int DATA_W = 32;
   localparam int ITERS = 32;
   localparam int CNT_W = 6;
   localparam logic [4:0] ALU_MULT = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;
   localparam logic [4:0] REG_EXC = 5'd30;
   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/multdiv_iter_unit_counter.sv
// md_iter_counter: iteration counter and one-cycle completion pulse for multdiv_iter_unit
module md_iter_counter
   import multdiv_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic last,
   output logic done
);
   logic [CNT_W-1:0] count;
   assign last = count == CNT_W'(ITERS);
   // Counts completed iterations; a new start restarts it, and it parks at ITERS
   always_ff @(posedge clock) begin
      if (reset || clear) count <= '0;
      else if (run && !last) count <= count + 1'b1;
   end
   // Completion pulse is raised on the edge that retires the final iteration
   always_ff @(posedge clock) begin
      done <= !reset && run && last;
   end
endmodule

// File: rtl/multdiv_iter_unit.sv
// multdiv_iter_unit: 33-cycle signed Booth multiply / restoring divide; divider is built only when MULTDIV_DIV_EN is defined
module multdiv_iter_unit
   import multdiv_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_operandA,
   input  logic [DATA_W-1:0] data_operandB,
   input  logic              ctrl_MULT,
   input  logic              ctrl_DIV,
   input  logic [4:0]        tag_in,
   output logic [DATA_W-1:0] data_result,
   output logic              data_exception,
   output logic              data_resultRDY,
   output logic              busy,
   output logic [4:0]        tag_out
);
   state_t state;
   logic [64:0] p;
   logic [31:0] m;
   logic [4:0] tag;
   logic start, accept, run, last;
   logic [32:0] acc, sum;
   logic [64:0] booth_next;
   logic [63:0] prod;
   assign start = ctrl_MULT ^ ctrl_DIV;
   assign accept = start && (state == S_IDLE || state == S_DONE);
   assign run = state == S_MULT || state == S_DIV;
   md_iter_counter u_cnt (
      .clock(clock),
      .reset(reset),
      .clear(accept),
      .run  (run),
      .last (last),
      .done (data_resultRDY)
   );
   // Booth step with a 33-bit accumulator so a -2^31 multiplicand cannot overflow before the shift
   always_comb begin
      acc = {p[64], p[64:33]};
      sum = p[1:0] == 2'b01 ? acc + {m[31], m} : p[1:0] == 2'b10 ? acc - {m[31], m} : acc;
      booth_next = {sum, p[32:1]};
      prod = p[64:1];
   end
`ifdef MULTDIV_DIV_EN
   logic neg, dz, ovf;
   logic [32:0] r, diff;
   logic [64:0] div_next;
   logic [31:0] quo;
   // Restoring step: p holds {remainder, quotient}; a borrow means restore and shift in 0
   always_comb begin
      r = {p[63:32], p[31]};
      diff = r - {1'b0, m};
      div_next = diff[32] ? {r, p[30:0], 1'b0} : {diff, p[30:0], 1'b1};
      quo = neg ? -p[31:0] : p[31:0];
   end
`endif
   // Control FSM and datapath registers; results only change when an operation retires
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         p <= '0;
         m <= '0;
         tag <= '0;
         busy <= 1'b0;
         data_result <= '0;
         data_exception <= 1'b0;
         tag_out <= '0;
`ifdef MULTDIV_DIV_EN
         neg <= 1'b0;
         dz <= 1'b0;
         ovf <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               if (accept) begin
                  tag <= tag_in;
                  busy <= 1'b1;
                  if (ctrl_MULT) begin
                     state <= S_MULT;
                     m <= data_operandA;
                     p <= {32'b0, data_operandB, 1'b0};
                  end else begin
                     state <= S_DIV;
`ifdef MULTDIV_DIV_EN
                     m <= data_operandB[31] ? -data_operandB : data_operandB;
                     p <= {33'b0, data_operandA[31] ? -data_operandA : data_operandA};
                     neg <= data_operandA[31] ^ data_operandB[31];
                     dz <= data_operandB == '0;
                     ovf <= data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
`endif
                  end
               end
            end
            S_MULT: begin
               if (last) begin
                  data_result <= prod[31:0];
                  data_exception <= prod[63:32] != {32{prod[31]}};
                  tag_out <= tag;
                  busy <= 1'b0;
                  state <= S_DONE;
               end else p <= booth_next;
            end
            S_DIV: begin
               if (last) begin
`ifdef MULTDIV_DIV_EN
                  data_result <= dz ? '0 : quo;
                  data_exception <= dz | ovf;
`else
                  data_result <= '0;
                  data_exception <= 1'b1;
`endif
                  tag_out <= tag;
                  busy <= 1'b0;
                  state <= S_DONE;
               end
`ifdef MULTDIV_DIV_EN
               else p <= div_next;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
